gtp_blkarb: RTL

//  Parametrised successor of the channel-block arbiter: merges data blocks from NCHAN per-channel

---
 rtl/gtp_blkarb_pkg.sv | 19 +
 rtl/gtp_blkarb_if.sv | 27 ++
 rtl/gtp_rrpick.sv | 27 ++
 rtl/gtp_blkarb.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/gtp_blkarb_pkg.sv
// Shared constants, FSM encoding and header helpers for the GTP lane-0 block arbiter.
package gtp_blkarb_pkg;

    localparam logic [15:0] KCOMMA_DEF = 16'h50BC;
    localparam logic [7:0]  KTRIG_DEF  = 8'h1C;

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    // Length field sits in the low lenw bits of the header; upper bits are payload.
    function automatic logic [63:0] hdr_len(input logic [63:0] hdr, input int unsigned lenw);
        logic [63:0] m;
        m = (64'd1 << lenw) - 64'd1;
        return hdr & m;
    endfunction

endpackage

// File: rtl/gtp_blkarb_if.sv
// Channel-side and GTP-side signal bundle of the block arbiter.
interface gtp_blkarb_if #(
    parameter int unsigned NCHAN = 16,
    parameter int unsigned DW    = 16
);
    logic [NCHAN*DW-1:0] data;
    logic [NCHAN-1:0]    req;
    logic [NCHAN-1:0]    ack;
    logic [NCHAN-1:0]    mask;
    logic                trigger;
    logic [DW-1:0]       dout;
    logic                kchar;
    logic                busy;
    logic [15:0]         blkcnt;
    logic                err_len;

    modport master (
        output data, req, mask, trigger,
        input  ack, dout, kchar, busy, blkcnt, err_len
    );

    modport slave (
        input  data, req, mask, trigger,
        output ack, dout, kchar, busy, blkcnt, err_len
    );

endinterface

// File: rtl/gtp_rrpick.sv
// Combinational round-robin pick: first set bit of cand at or above ptr, wrapping around.
module gtp_rrpick #(
    parameter int unsigned  N  = 16,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  cand_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] gnt_o,
    output logic          valid_o
);

    int unsigned idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_i) + i) % N;
            if (!valid_o && cand_i[idx]) begin
                valid_o = 1'b1;
                gnt_o   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/gtp_blkarb.sv
// Merges length-prefixed channel blocks into one GTP word stream with idle commas
// and sequence-numbered trigger K-chars.
module gtp_blkarb
    import gtp_blkarb_pkg::*;
#(
    parameter int unsigned NCHAN  = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned LENW   = 9,
    parameter int unsigned MAXLEN = 255,
    parameter logic [15:0] KCOMMA = KCOMMA_DEF,
    parameter logic [7:0]  KTRIG  = KTRIG_DEF
) (
    input logic        clk,
    input logic        rst_n,
    gtp_blkarb_if.slave bus
);

    localparam int unsigned PW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            first_q, first_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            kchar_q, kchar_d;
    logic [15:0]     blkcnt_q, blkcnt_d;
    logic            err_q, err_d;
    logic [7:0]      trigseq_q, trigseq_d;

    logic [NCHAN-1:0] ack;
    logic [PW-1:0]    pick_gnt;
    logic             pick_valid;
    logic [DW-1:0]    word;
    logic [63:0]      hlen;
    logic             clip;
    logic [LENW-1:0]  start_len;
    logic             acked;
    logic             last;

    gtp_rrpick #(
        .N(NCHAN)
    ) u_pick (
        .cand_i (bus.req & bus.mask),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .valid_o(pick_valid)
    );

    assign word      = bus.data[32'(gnt_q) * DW +: DW];
    assign hlen      = hdr_len(64'(word), LENW);
    assign clip      = hlen > 64'(MAXLEN);
    assign start_len = clip ? LENW'(MAXLEN) : LENW'(hlen);
    // A trigger slot steals the cycle: the granted channel simply holds its word.
    assign acked     = (state_q == StSend) && !bus.trigger;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        rem_d     = rem_q;
        blkcnt_d  = blkcnt_q;
        err_d     = err_q;
        trigseq_d = trigseq_q;
        ack       = '0;
        last      = 1'b0;
        dout_d    = DW'(KCOMMA);
        kchar_d   = 1'b1;

        if (bus.trigger) begin
            dout_d    = DW'({trigseq_q, KTRIG});
            trigseq_d = trigseq_q + 8'd1;
        end else if (acked) begin
            dout_d  = word;
            kchar_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    ptr_d   = (pick_gnt == PW'(NCHAN - 1)) ? '0 : pick_gnt + 1'b1;
                    state_d = StSend;
                    first_d = 1'b1;
                end
            end
            StSend: begin
                if (acked) begin
                    ack[gnt_q] = 1'b1;
                    if (first_q) begin
                        first_d = 1'b0;
                        rem_d   = start_len;
                        last    = (start_len == '0);
                        if (clip) err_d = 1'b1;
                    end else begin
                        rem_d = rem_q - 1'b1;
                        last  = (rem_q == LENW'(1));
                    end
                    if (last) begin
                        state_d  = StIdle;
                        blkcnt_d = blkcnt_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            ptr_q     <= '0;
            first_q   <= 1'b0;
            rem_q     <= '0;
            dout_q    <= DW'(KCOMMA);
            kchar_q   <= 1'b1;
            blkcnt_q  <= '0;
            err_q     <= 1'b0;
            trigseq_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            first_q   <= first_d;
            rem_q     <= rem_d;
            dout_q    <= dout_d;
            kchar_q   <= kchar_d;
            blkcnt_q  <= blkcnt_d;
            err_q     <= err_d;
            trigseq_q <= trigseq_d;
        end
    end

    assign bus.ack     = ack;
    assign bus.dout    = dout_q;
    assign bus.kchar   = kchar_q;
    assign bus.busy    = (state_q == StSend);
    assign bus.blkcnt  = blkcnt_q;
    assign bus.err_len = err_q;

endmodule
